// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences each instruction through
// fetch/decode/execute/memory/writeback, handles variable-latency memory
// with a bus-error timeout, traps illegal opcodes and counts retired
// instructions.
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32,
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             memReady,
  output logic             ctrlIorD,
  output logic             ctrlMemRead,
  output logic             ctrlMemWrite,
  output logic             ctrlIRWrite,
  output logic             ctrlRegDst,
  output logic             ctrlMemToReg,
  output logic             ctrlRegWrite,
  output logic             ctrlALUSrcA,
  output logic [1:0]       ctrlALUSrcB,
  output logic [1:0]       ctrlALUOp,
  output logic [1:0]       ctrlPCSrc,
  output logic             ctrlPCEn,
  output logic             ctrlException,
  output logic [1:0]       ctrlExcCause,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retiredCount
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  // Wait counter only needs to reach MEM_TIMEOUT-1; with the timeout
  // disabled it simply wraps and is ignored.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  state_t            st;
  logic [WAIT_W-1:0] waitCnt;
  logic              timeout;

  // memReady in the expiring cycle wins, hence the !memReady term
  assign timeout = (MEM_TIMEOUT > 0) && (waitCnt == WAIT_LAST) && !memReady;
  assign state   = st;

  // State sequencing, memory wait counter, trap cause and retire counter.
  // waitCnt is zeroed in every non-waiting cycle, so it is always zero on
  // entry to FETCH, MEMRD and MEMWR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= FETCH;
      waitCnt      <= '0;
      retiredCount <= '0;
      ctrlExcCause <= 2'b00;
    end else begin
      waitCnt <= '0;
      case (st)
        FETCH: begin
          if (memReady) begin
            st <= DECODE;
          end else if (timeout) begin
            st           <= TRAP;
            ctrlExcCause <= CAUSE_BUS;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: st <= MEMADR;
            OP_RTYPE:     st <= EXEC;
            OP_BEQ:       st <= BRANCH;
            OP_ADDI:      st <= ADDIEX;
            OP_J: begin
              if (ENABLE_JUMP) begin
                st <= JUMP;
              end else begin
                st           <= TRAP;
                ctrlExcCause <= CAUSE_ILLEGAL;
              end
            end
            default: begin
              st           <= TRAP;
              ctrlExcCause <= CAUSE_ILLEGAL;
            end
          endcase
        end
        MEMADR: st <= (opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD: begin
          if (memReady) begin
            st <= MEMWB;
          end else if (timeout) begin
            st           <= TRAP;
            ctrlExcCause <= CAUSE_BUS;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        MEMWR: begin
          if (memReady) begin
            st           <= FETCH;
            retiredCount <= retiredCount + CNT_W'(1);
          end else if (timeout) begin
            st           <= TRAP;
            ctrlExcCause <= CAUSE_BUS;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: begin
          st           <= FETCH;
          retiredCount <= retiredCount + CNT_W'(1);
        end
        EXEC:    st <= ALUWB;
        ADDIEX:  st <= ADDIWB;
        TRAP:    st <= FETCH;
        default: st <= FETCH;
      endcase
    end
  end

  // Moore decode of datapath controls; only FETCH (memReady) and
  // BRANCH (zero) look at inputs.
  always_comb begin
    ctrlIorD      = 1'b0;
    ctrlMemRead   = 1'b0;
    ctrlMemWrite  = 1'b0;
    ctrlIRWrite   = 1'b0;
    ctrlRegDst    = 1'b0;
    ctrlMemToReg  = 1'b0;
    ctrlRegWrite  = 1'b0;
    ctrlALUSrcA   = 1'b0;
    ctrlALUSrcB   = 2'b00;
    ctrlALUOp     = 2'b00;
    ctrlPCSrc     = 2'b00;
    ctrlPCEn      = 1'b0;
    ctrlException = 1'b0;
    case (st)
      FETCH: begin
        ctrlMemRead = 1'b1;
        ctrlALUSrcB = 2'b01;
        ctrlIRWrite = memReady;
        ctrlPCEn    = memReady;
      end
      DECODE: ctrlALUSrcB = 2'b11;
      MEMADR: begin
        ctrlALUSrcA = 1'b1;
        ctrlALUSrcB = 2'b10;
      end
      MEMRD: begin
        ctrlMemRead = 1'b1;
        ctrlIorD    = 1'b1;
      end
      MEMWB: begin
        ctrlRegWrite = 1'b1;
        ctrlMemToReg = 1'b1;
      end
      MEMWR: begin
        ctrlMemWrite = 1'b1;
        ctrlIorD     = 1'b1;
      end
      EXEC: begin
        ctrlALUSrcA = 1'b1;
        ctrlALUOp   = 2'b10;
      end
      ALUWB: begin
        ctrlRegWrite = 1'b1;
        ctrlRegDst   = 1'b1;
      end
      BRANCH: begin
        ctrlALUSrcA = 1'b1;
        ctrlALUOp   = 2'b01;
        ctrlPCSrc   = 2'b01;
        ctrlPCEn    = zero;
      end
      ADDIEX: begin
        ctrlALUSrcA = 1'b1;
        ctrlALUSrcB = 2'b10;
      end
      ADDIWB: ctrlRegWrite = 1'b1;
      JUMP: begin
        ctrlPCSrc = 2'b10;
        ctrlPCEn  = 1'b1;
      end
      TRAP: begin
        ctrlException = 1'b1;
        ctrlPCSrc     = 2'b11;
        ctrlPCEn      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: instance a uses default parameters,
// instance b uses a 4-cycle timeout, jump disabled and a 4-bit counter.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // instance a signals
  logic        rst_a, zero_a, rdy_a;
  logic [5:0]  op_a;
  logic        iord_a, mrd_a, mwr_a, irw_a, rdst_a, m2r_a, rw_a, srca_a, pcen_a, exc_a;
  logic [1:0]  srcb_a, aluop_a, pcsrc_a, cause_a;
  logic [3:0]  st_a;
  logic [31:0] ret_a;

  // instance b signals
  logic        rst_b, zero_b, rdy_b;
  logic [5:0]  op_b;
  logic        iord_b, mrd_b, mwr_b, irw_b, rdst_b, m2r_b, rw_b, srca_b, pcen_b, exc_b;
  logic [1:0]  srcb_b, aluop_b, pcsrc_b, cause_b;
  logic [3:0]  st_b;
  logic [3:0]  ret_b;

  mc_ctrl_fsm u_a (
    .clk(clk), .rst(rst_a), .opcode(op_a), .zero(zero_a), .memReady(rdy_a),
    .ctrlIorD(iord_a), .ctrlMemRead(mrd_a), .ctrlMemWrite(mwr_a),
    .ctrlIRWrite(irw_a), .ctrlRegDst(rdst_a), .ctrlMemToReg(m2r_a),
    .ctrlRegWrite(rw_a), .ctrlALUSrcA(srca_a), .ctrlALUSrcB(srcb_a),
    .ctrlALUOp(aluop_a), .ctrlPCSrc(pcsrc_a), .ctrlPCEn(pcen_a),
    .ctrlException(exc_a), .ctrlExcCause(cause_a), .state(st_a),
    .retiredCount(ret_a)
  );

  mc_ctrl_fsm #(.MEM_TIMEOUT(4), .CNT_W(4), .ENABLE_JUMP(1'b0)) u_b (
    .clk(clk), .rst(rst_b), .opcode(op_b), .zero(zero_b), .memReady(rdy_b),
    .ctrlIorD(iord_b), .ctrlMemRead(mrd_b), .ctrlMemWrite(mwr_b),
    .ctrlIRWrite(irw_b), .ctrlRegDst(rdst_b), .ctrlMemToReg(m2r_b),
    .ctrlRegWrite(rw_b), .ctrlALUSrcA(srca_b), .ctrlALUSrcB(srcb_b),
    .ctrlALUOp(aluop_b), .ctrlPCSrc(pcsrc_b), .ctrlPCEn(pcen_b),
    .ctrlException(exc_b), .ctrlExcCause(cause_b), .state(st_b),
    .retiredCount(ret_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs are then changed and outputs sampled mid-cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; zero_a = 1'b0; rdy_a = 1'b0; op_a = 6'b000000;
    rst_b = 1'b1; zero_b = 1'b0; rdy_b = 1'b0; op_b = 6'b000000;
    #2;
    // ---- reset state of instance a
    check("rst_state",   32'(st_a),    32'd0);
    check("rst_memread", 32'(mrd_a),   32'd1);
    check("rst_alusrcb", 32'(srcb_a),  32'd1);
    check("rst_pcen",    32'(pcen_a),  32'd0);
    check("rst_irwrite", 32'(irw_a),   32'd0);
    check("rst_cause",   32'(cause_a), 32'd0);
    check("rst_retired", ret_a,        32'd0);
    tick();
    rst_a = 1'b0;
    #1;
    // ---- fetch wait: three cycles with memReady low
    check("fw_state0", 32'(st_a),   32'd0);
    check("fw_pcen0",  32'(pcen_a), 32'd0);
    tick();
    tick();
    check("fw_state2",   32'(st_a),  32'd0);
    check("fw_memread2", 32'(mrd_a), 32'd1);
    check("fw_irw2",     32'(irw_a), 32'd0);
    rdy_a = 1'b1;
    #1;
    check("fw_irw_rdy",  32'(irw_a),  32'd1);
    check("fw_pcen_rdy", 32'(pcen_a), 32'd1);
    // ---- R-type
    op_a = 6'b000000;
    tick();
    check("r_decode",  32'(st_a),   32'd1);
    check("r_dec_srcb",32'(srcb_a), 32'd3);
    tick();
    check("r_exec",    32'(st_a),    32'd6);
    check("r_aluop",   32'(aluop_a), 32'd2);
    check("r_srca",    32'(srca_a),  32'd1);
    tick();
    check("r_aluwb",   32'(st_a),   32'd7);
    check("r_regwr",   32'(rw_a),   32'd1);
    check("r_regdst",  32'(rdst_a), 32'd1);
    tick();
    check("r_fetch",   32'(st_a), 32'd0);
    check("r_retired", ret_a,     32'd1);
    // ---- lw with two wait cycles in MEMRD
    op_a = 6'b100011;
    tick();
    check("lw_decode", 32'(st_a), 32'd1);
    tick();
    check("lw_memadr", 32'(st_a),   32'd2);
    check("lw_srcb",   32'(srcb_a), 32'd2);
    rdy_a = 1'b0;
    tick();
    check("lw_memrd0", 32'(st_a),   32'd3);
    check("lw_iord",   32'(iord_a), 32'd1);
    check("lw_mrd",    32'(mrd_a),  32'd1);
    tick();
    check("lw_memrd1", 32'(st_a), 32'd3);
    tick();
    check("lw_memrd2", 32'(st_a), 32'd3);
    rdy_a = 1'b1;
    tick();
    check("lw_memwb",  32'(st_a),  32'd4);
    check("lw_regwr",  32'(rw_a),  32'd1);
    check("lw_m2r",    32'(m2r_a), 32'd1);
    check("lw_rdst",   32'(rdst_a),32'd0);
    tick();
    check("lw_fetch",  32'(st_a), 32'd0);
    check("lw_retired",ret_a,     32'd2);
    // ---- sw
    op_a = 6'b101011;
    tick();
    tick();
    check("sw_memadr", 32'(st_a), 32'd2);
    tick();
    check("sw_memwr",  32'(st_a),   32'd5);
    check("sw_mwr",    32'(mwr_a),  32'd1);
    check("sw_iord",   32'(iord_a), 32'd1);
    tick();
    check("sw_fetch",  32'(st_a), 32'd0);
    check("sw_retired",ret_a,     32'd3);
    // ---- beq taken
    op_a = 6'b000100;
    zero_a = 1'b1;
    tick();
    tick();
    check("beq1_state", 32'(st_a),    32'd8);
    check("beq1_pcen",  32'(pcen_a),  32'd1);
    check("beq1_pcsrc", 32'(pcsrc_a), 32'd1);
    check("beq1_aluop", 32'(aluop_a), 32'd1);
    tick();
    check("beq1_retired", ret_a, 32'd4);
    // ---- beq not taken
    zero_a = 1'b0;
    tick();
    tick();
    check("beq0_state", 32'(st_a),   32'd8);
    check("beq0_pcen",  32'(pcen_a), 32'd0);
    tick();
    check("beq0_fetch",   32'(st_a), 32'd0);
    check("beq0_retired", ret_a,     32'd5);
    // ---- j (enabled)
    op_a = 6'b000010;
    tick();
    tick();
    check("j_state", 32'(st_a),    32'd11);
    check("j_pcsrc", 32'(pcsrc_a), 32'd2);
    check("j_pcen",  32'(pcen_a),  32'd1);
    tick();
    check("j_retired", ret_a, 32'd6);
    // ---- addi
    op_a = 6'b001000;
    tick();
    tick();
    check("addi_ex",   32'(st_a),   32'd9);
    check("addi_srcb", 32'(srcb_a), 32'd2);
    tick();
    check("addi_wb",    32'(st_a),   32'd10);
    check("addi_regwr", 32'(rw_a),   32'd1);
    check("addi_rdst",  32'(rdst_a), 32'd0);
    tick();
    check("addi_retired", ret_a, 32'd7);
    // ---- illegal opcode
    op_a = 6'b111111;
    tick();
    tick();
    check("ill_state", 32'(st_a),    32'd12);
    check("ill_exc",   32'(exc_a),   32'd1);
    check("ill_cause", 32'(cause_a), 32'd1);
    check("ill_pcsrc", 32'(pcsrc_a), 32'd3);
    check("ill_pcen",  32'(pcen_a),  32'd1);
    tick();
    check("ill_fetch",   32'(st_a),    32'd0);
    check("ill_exc_end", 32'(exc_a),   32'd0);
    check("ill_cause_h", 32'(cause_a), 32'd1);
    check("ill_retired", ret_a,        32'd7);
    // ---- reset in the middle of MEMRD
    op_a = 6'b100011;
    tick();
    tick();
    rdy_a = 1'b0;
    tick();
    check("mrst_memrd", 32'(st_a), 32'd3);
    rst_a = 1'b1;
    #1;
    check("mrst_state", 32'(st_a), 32'd0);
    check("mrst_regwr", 32'(rw_a), 32'd0);
    check("mrst_ret",   ret_a,     32'd0);
    rdy_a = 1'b1;
    tick();
    check("mrst_regwr2", 32'(rw_a), 32'd0);
    rst_a = 1'b0;

    // ---- instance b: fetch timeout after 4 cycles
    rst_b = 1'b0;
    #1;
    check("to_state0", 32'(st_b), 32'd0);
    tick();
    tick();
    tick();
    check("to_state3", 32'(st_b), 32'd0);
    tick();
    check("to_trap",  32'(st_b),    32'd12);
    check("to_exc",   32'(exc_b),   32'd1);
    check("to_cause", 32'(cause_b), 32'd2);
    tick();
    check("to_fetch",   32'(st_b),    32'd0);
    check("to_cause_h", 32'(cause_b), 32'd2);
    // ready on the 4th cycle completes normally
    tick();
    tick();
    tick();
    check("tr_state3", 32'(st_b), 32'd0);
    rdy_b = 1'b1;
    tick();
    check("tr_decode", 32'(st_b), 32'd1);
    // j with jump disabled traps as illegal
    op_b = 6'b000010;
    tick();
    check("jd_trap",  32'(st_b),    32'd12);
    check("jd_exc",   32'(exc_b),   32'd1);
    check("jd_cause", 32'(cause_b), 32'd1);
    tick();
    check("jd_retired", 32'(ret_b), 32'd0);
    // counter wrap with 16 beq instructions on a 4-bit counter
    op_b = 6'b000100;
    for (int i = 0; i < 15; i++) begin
      tick();
      tick();
      tick();
    end
    check("wrap_15", 32'(ret_b), 32'd15);
    tick();
    tick();
    tick();
    check("wrap_0", 32'(ret_b), 32'd0);
    check("wrap_fetch", 32'(st_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle MIPS control unit and the successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. Memory accesses use a ready handshake with variable latency and a bus-error timeout. Illegal opcodes trap. It drives the multi-cycle datapath muxes and enables, and keeps a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 15, max wait cycles per memory access before bus-error trap; 0 disables the timeout
CNT_W, 32, width of retiredCount
ENABLE_JUMP, 1, when 0 the j opcode (000010) is treated as illegal

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag
memReady  in  1  memory completes the current access this cycle
ctrlIorD  out  1  memory address select: 0 = PC, 1 = ALUOut
ctrlMemRead  out  1  memory read request
ctrlMemWrite  out  1  memory write request
ctrlIRWrite  out  1  IR load
ctrlRegDst  out  1  write register select: 1 = rd, 0 = rt
ctrlMemToReg  out  1  write data select: 1 = MDR, 0 = ALUOut
ctrlRegWrite  out  1  register file write
ctrlALUSrcA  out  1  ALU A select: 0 = PC, 1 = regA
ctrlALUSrcB  out  2  ALU B select: 00 regB, 01 const 4, 10 sext imm, 11 sext imm<<2
ctrlALUOp  out  2  00 add, 01 subtract, 10 use funct
ctrlPCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector
ctrlPCEn  out  1  PC load enable
ctrlException  out  1  one-cycle trap pulse
ctrlExcCause  out  2  00 none, 01 illegal opcode, 10 bus timeout; held until the next trap or reset
state  out  4  current state code, for debug
retiredCount  out  CNT_W  count of completed instructions, wraps

Behaviour:
- Reset (async, rst=1):
  - state=FETCH(0), waitCnt=0, retiredCount=0, ctrlExcCause=00.
  - Outputs are decoded from FETCH with memReady gating: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; all else 0.
- Outputs are Moore, decoded from the state register, with two exceptions:
  - In FETCH, IRWrite and PCEn are gated by memReady.
  - In BRANCH, PCEn = zero.
- State codes and transitions:
  - FETCH(0): MemRead. If memReady: IRWrite=1, PCEn=1 (PC+4), go to DECODE; otherwise hold.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Dispatch on opcode:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXEC
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP if ENABLE_JUMP, else TRAP
    - any other opcode -> TRAP (cause 01)
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for lw, MEMWR for sw.
  - MEMRD(3): MemRead=1, IorD=1. Go to MEMWB on memReady; otherwise hold.
  - MEMWB(4): RegWrite=1, MemToReg=1, RegDst=0 -> FETCH.
  - MEMWR(5): MemWrite=1, IorD=1. Go to FETCH on memReady; otherwise hold.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - ALUWB(7): RegWrite=1, RegDst=1, MemToReg=0 -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCEn=zero -> FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - ADDIWB(10): RegWrite=1, RegDst=0, MemToReg=0 -> FETCH.
  - JUMP(11): PCSrc=10, PCEn=1 -> FETCH.
  - TRAP(12): Exception=1, PCSrc=11, PCEn=1 -> FETCH. Codes 13-15 are unreachable and recover to FETCH.
- Latencies with zero-wait memory:
  - R-type and addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq and j: 3 cycles
- Memory timeout:
  - waitCnt clears on entry to FETCH, MEMRD and MEMWR, and increments each cycle memReady=0.
  - If MEM_TIMEOUT>0, waitCnt==MEM_TIMEOUT-1 and memReady=0, go to TRAP with cause 10.
  - memReady in the same cycle as the timeout wins (normal completion).
- ctrlExcCause is written on entry to TRAP.
- retiredCount increments by 1 on exits to FETCH from MEMWB, MEMWR, ALUWB, BRANCH (taken or not), ADDIWB and JUMP. It does not increment on TRAP. It wraps at 2^CNT_W.
- rst asserted mid-instruction returns immediately to FETCH. No partial writes complete after reset.

Test Plan:
- Reset, then hold memReady=0 for 3 cycles, then 1 -> state stays 0, MemRead=1, PCEn=0 while waiting. In the ready cycle IRWrite=PCEn=1; next state=1.
- R-type (opcode 000000), memReady always 1 -> state sequence 0,1,6,7,0. ALUOp=10 in EXEC, RegWrite=RegDst=1 in ALUWB. retiredCount 0->1.
- lw with memReady low 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0, IorD=1 in MEMRD. sw follows 0,1,2,5,0 with MemWrite=1. retiredCount increments once per instruction.
- beq with zero=1, then zero=0 -> PCEn=1 and PCEn=0 respectively in BRANCH, PCSrc=01, ALUOp=01. Both retire.
- opcode 111111; separately j with ENABLE_JUMP=0 -> TRAP: Exception pulse 1 cycle, ExcCause=01, PCSrc=11, PCEn=1. retiredCount unchanged.
- MEM_TIMEOUT=4, memReady stuck 0 in FETCH -> TRAP after 4 cycles, ExcCause=10. Repeat with memReady=1 on the 4th cycle -> normal DECODE. rst mid-MEMRD -> state=0, RegWrite never asserted.
